// File: rtl/lut_prog.sv
`default_nettype none
// ============================================================================
// lut_prog : serially loaded lookup table with a valid/ready lookup port
// Rev 1.0
// ============================================================================
module lut_prog #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic                 cfg_bit_valid,
    input  logic                 cfg_bit,
    output logic                 cfg_busy,
    output logic                 cfg_done,
    input  logic                 in_valid,
    input  logic [IN_W-1:0]      in_addr,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [OUT_W-1:0]     out_data,
    input  logic                 out_ready,
    output logic [2**IN_W-1:0]   nz_map
);
    localparam int DEPTH = 2**IN_W;
    localparam int TOTAL = DEPTH * OUT_W;
    localparam int K_W   = $clog2(TOTAL);
    localparam logic [K_W-1:0] K_LAST = K_W'(TOTAL - 1);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t           state_q;
    logic [K_W-1:0]   k_q;
    logic [TOTAL-1:0] table_q;
    logic             out_valid_q;
    logic [OUT_W-1:0] out_data_q;
    logic             cfg_done_q;
    logic [DEPTH-1:0] nz_q;

    logic [K_W-1:0]   rd_base;
    logic [OUT_W-1:0] out_data_d;
    logic             accept;

    // Table is stored flat: entry e occupies bits [e*OUT_W +: OUT_W].
    assign rd_base    = K_W'(in_addr) * K_W'(OUT_W);
    assign out_data_d = table_q[rd_base +: OUT_W];
    assign in_ready   = (state_q == RUN) && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;

    assign cfg_busy  = (state_q == LOAD);
    assign cfg_done  = cfg_done_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign nz_map    = nz_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            k_q         <= '0;
            table_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cfg_done_q  <= 1'b0;
            nz_q        <= '0;
        end else begin
            cfg_done_q <= 1'b0;

            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= out_data_d;
                if (out_data_d != '0) begin
                    nz_q[in_addr] <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            // The clear on entering LOAD deliberately overrides a same-cycle nz set.
            case (state_q)
                RUN: begin
                    if (cfg_start) begin
                        state_q <= LOAD;
                        k_q     <= '0;
                        nz_q    <= '0;
                    end
                end
                LOAD: begin
                    if (cfg_bit_valid) begin
                        table_q[k_q] <= cfg_bit;
                        if (k_q == K_LAST) begin
                            state_q    <= RUN;
                            k_q        <= '0;
                            cfg_done_q <= 1'b1;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_lut_prog.sv
`default_nettype none
// ============================================================================
// tb_lut_prog : scoreboard bench for lut_prog (4x1 and 2x2 instances)
// Rev 1.0
// ============================================================================
module tb_lut_prog;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       cs[2], cbv[2], cb[2], iv[2], ordy[2];
    logic [3:0] ia[2];
    logic       busy[2], done[2], irdy[2], ov[2];
    logic [1:0] od[2];
    logic [15:0] nz[2];
    logic [0:0] od_a;
    logic [1:0] od_b;
    logic [15:0] nz_a;
    logic [3:0] nz_b;

    assign od[0] = {1'b0, od_a};
    assign od[1] = od_b;
    assign nz[0] = nz_a;
    assign nz[1] = {12'b0, nz_b};

    lut_prog #(.IN_W(4), .OUT_W(1)) u_a (
        .clk(clk), .rst(rst),
        .cfg_start(cs[0]), .cfg_bit_valid(cbv[0]), .cfg_bit(cb[0]),
        .cfg_busy(busy[0]), .cfg_done(done[0]),
        .in_valid(iv[0]), .in_addr(ia[0]), .in_ready(irdy[0]),
        .out_valid(ov[0]), .out_data(od_a), .out_ready(ordy[0]),
        .nz_map(nz_a)
    );

    lut_prog #(.IN_W(2), .OUT_W(2)) u_b (
        .clk(clk), .rst(rst),
        .cfg_start(cs[1]), .cfg_bit_valid(cbv[1]), .cfg_bit(cb[1]),
        .cfg_busy(busy[1]), .cfg_done(done[1]),
        .in_valid(iv[1]), .in_addr(ia[1][1:0]), .in_ready(irdy[1]),
        .out_valid(ov[1]), .out_data(od_b), .out_ready(ordy[1]),
        .nz_map(nz_b)
    );

    // Reference model: table as a plain bit vector, load progress as a bit count.
    int          OW[2]  = '{1, 2};
    int          TOT[2] = '{16, 8};
    logic [15:0] m_tbl[2];
    logic [15:0] m_nz[2];
    bit          m_load[2];
    int          m_k[2];
    bit          m_done[2];
    logic [1:0]  q0[$];
    logic [1:0]  q1[$];
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_lookup(input int id, input int addr);
        return (int'(m_tbl[id]) >> (addr * OW[id])) & ((1 << OW[id]) - 1);
    endfunction

    task automatic mon(input int id);
        int sz = (id == 0) ? q0.size() : q1.size();
        logic [1:0] e;
        if (ov[id]) begin
            if (sz == 0) begin
                chk("out_valid_spurious", 1, 0);
            end else begin
                e = (id == 0) ? q0[0] : q1[0];
                chk("out_data", od[id], e);
                if (ordy[id]) begin
                    if (id == 0) void'(q0.pop_front());
                    else         void'(q1.pop_front());
                end
            end
        end else if (sz != 0) begin
            chk("out_valid_missing", 0, 1);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0);
            mon(1);
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
        for (int id = 0; id < 2; id++) begin
            int sz = (id == 0) ? q0.size() : q1.size();
            chk("cfg_busy", busy[id], m_load[id]);
            chk("cfg_done", done[id], m_done[id]);
            chk("in_ready", irdy[id], !m_load[id] && (sz == 0 || ordy[id]));
            chk("nz_map", nz[id], m_nz[id]);
            m_done[id] = 0;
            if (iv[id] && irdy[id]) begin
                int v = m_lookup(id, int'(ia[id]));
                if (id == 0) q0.push_back(2'(v));
                else         q1.push_back(2'(v));
                if (v != 0) m_nz[id][ia[id]] = 1'b1;
            end
            if (!m_load[id]) begin
                if (cs[id]) begin
                    m_load[id] = 1;
                    m_k[id]    = 0;
                    m_nz[id]   = '0;
                end
            end else if (cbv[id]) begin
                m_tbl[id][m_k[id]] = cb[id];
                if (m_k[id] == TOT[id] - 1) begin
                    m_load[id] = 0;
                    m_done[id] = 1;
                    m_k[id]    = 0;
                end else begin
                    m_k[id]++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int id = 0; id < 2; id++) begin
            m_tbl[id]  = '0;
            m_nz[id]   = '0;
            m_load[id] = 0;
            m_k[id]    = 0;
            m_done[id] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        for (int id = 0; id < 2; id++) chk("rst_busy_async", busy[id], 0);
        model_clear();
        @(posedge clk);
        #1;
        for (int id = 0; id < 2; id++) begin
            chk("rst_out_valid", ov[id], 0);
            chk("rst_out_data", od[id], 0);
            chk("rst_cfg_done", done[id], 0);
            chk("rst_nz_map", nz[id], 0);
        end
        rst = 1'b0;
    endtask

    task automatic load(input int id, input logic [15:0] bits, input int n,
                        input int gap, input bit start);
        if (start) begin
            cs[id] = 1'b1;
            step();
            cs[id] = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            cbv[id] = 1'b1;
            cb[id]  = bits[i];
            step();
            cbv[id] = 1'b0;
            cb[id]  = 1'b0;
            for (int g = 0; g < gap; g++) step();
        end
    endtask

    task automatic lookup(input int id, input int addr);
        iv[id] = 1'b1;
        ia[id] = 4'(addr);
        step();
        iv[id] = 1'b0;
    endtask

    initial begin
        for (int id = 0; id < 2; id++) begin
            cs[id] = 0; cbv[id] = 0; cb[id] = 0; iv[id] = 0; ia[id] = '0; ordy[id] = 1;
        end
        do_reset();
        step();

        // Empty table returns zero
        lookup(0, 5);
        lookup(1, 2);
        step();

        // 4x1 table load and back-to-back lookups
        load(0, 16'hFF4C, 16, 0, 1);
        step();
        lookup(0, 6);
        lookup(0, 5);
        lookup(0, 15);
        lookup(0, 0);
        step();
        chk("nz_after_lookups", nz[0], 16'h8040);

        // Back-pressure: address 2 stalls, address 3 waits for the drain
        ordy[0] = 1'b0;
        iv[0] = 1'b1;
        ia[0] = 4'd2;
        step();
        ia[0] = 4'd3;
        step();
        step();
        chk("stall_data_hold", od[0], 1);
        ordy[0] = 1'b1;
        step();
        iv[0] = 1'b0;
        step();
        step();

        // cfg_start together with a lookup uses the old table
        cs[0] = 1'b1;
        iv[0] = 1'b1;
        ia[0] = 4'd8;
        step();
        cs[0] = 1'b0;
        iv[0] = 1'b0;
        chk("nz_cleared_on_load", nz[0], 0);
        load(0, 16'h0000, 16, 3, 0);
        lookup(0, 8);
        step();

        // Reset in the middle of a load wipes the table
        load(0, 16'hFFFF, 16, 0, 1);
        step();
        load(0, 16'h0000, 7, 0, 1);
        do_reset();
        lookup(0, 15);
        step();

        // 2x2 table
        load(1, 16'h00E4, 8, 0, 1);
        step();
        lookup(1, 0);
        lookup(1, 1);
        lookup(1, 2);
        lookup(1, 3);
        step();
        chk("nz_2x2", nz[1], 16'h000E);

        // Randomized traffic on both instances
        for (int c = 0; c < 600; c++) begin
            for (int id = 0; id < 2; id++) begin
                cs[id]   = ($urandom_range(0, 39) == 0);
                cbv[id]  = ($urandom_range(0, 2) != 0);
                cb[id]   = 1'($urandom_range(0, 1));
                iv[id]   = 1'($urandom_range(0, 1));
                ia[id]   = 4'($urandom_range(0, (id == 0) ? 15 : 3));
                ordy[id] = ($urandom_range(0, 3) != 0);
            end
            step();
        end

        for (int id = 0; id < 2; id++) begin
            cs[id] = 0; cbv[id] = 0; iv[id] = 0; ordy[id] = 1;
        end
        repeat (3) step();
        chk("scoreboard_drained", q0.size() + q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
